fb_swap_ctrl: RTL and testbench

Avalon-MM controlled page-flip sequencer for the frame buffer. Drives the display read-buffer select and the draw-target select. Software requests a swap; the block commits it on the next vertical-blank rising edge, or immediately on request, then counts the swap and optionally interrupts. It sits between the HPS/NIOS bus and the VGA read path, in place of raw PIO select bits.

---
 rtl/fb_swap_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// rtl/fb_swap_ctrl.sv - Avalon-MM page-flip sequencer for the frame buffer
// Optional IRQ flag/enable/irq output built only when FB_SWAP_IRQ_EN is defined.
module fb_swap_ctrl #(
  parameter int BUF_IDX_W = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic                 vsync,
  output logic [BUF_IDX_W-1:0] rd_buf,
  output logic [BUF_IDX_W-1:0] wr_buf,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 vsync_q;
  logic [BUF_IDX_W-1:0] rd_buf_q, rd_buf_d;
  logic [BUF_IDX_W-1:0] wr_buf_q, wr_buf_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]     swap_cnt_q, swap_cnt_d;

  logic wr_stb;
  logic ctrl_wr;
  logic status_wr;
  logic vs_rise;
  logic commit;

  assign wr_stb    = chipselect & ~write_n;
  assign ctrl_wr   = wr_stb && (address == 2'd0);
  assign status_wr = wr_stb && (address == 2'd1);
  assign vs_rise   = vsync & ~vsync_q;
  assign commit    = (state_q == ST_COMMIT);

  // A swap request arriving alongside a vsync edge only arms PENDING; it
  // waits for the next rise, so no edge is consumed from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && writedata[0]) begin
          state_d = writedata[1] ? ST_COMMIT : ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (ctrl_wr && writedata[3]) begin
          state_d = ST_IDLE;
        end else if (vs_rise) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_buf_d    = rd_buf_q;
    wr_buf_d    = wr_buf_q;
    swap_cnt_d  = swap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (commit) begin
      rd_buf_d   = wr_buf_q;
      wr_buf_d   = wr_buf_q + BUF_IDX_W'(1);
      swap_cnt_d = swap_cnt_q + CNT_W'(1);
    end
    if (vs_rise) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vsync_q     <= 1'b0;
      rd_buf_q    <= '0;
      wr_buf_q    <= BUF_IDX_W'(1);
      frame_cnt_q <= '0;
      swap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      rd_buf_q    <= rd_buf_d;
      wr_buf_q    <= wr_buf_d;
      frame_cnt_q <= frame_cnt_d;
      swap_cnt_q  <= swap_cnt_d;
    end
  end

`ifdef FB_SWAP_IRQ_EN
  logic irq_flag_q, irq_flag_d;
  logic irq_en_q, irq_en_d;

  // Setting on COMMIT takes priority over a same-cycle software clear.
  always_comb begin
    irq_flag_d = irq_flag_q;
    irq_en_d   = irq_en_q;
    if (commit) begin
      irq_flag_d = 1'b1;
    end else if (status_wr && writedata[1]) begin
      irq_flag_d = 1'b0;
    end
    if (ctrl_wr) begin
      irq_en_d = writedata[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      irq_flag_q <= irq_flag_d;
      irq_en_q   <= irq_en_d;
    end
  end
`else
  logic irq_flag_q;
  logic irq_en_q;
  logic unused_status_wr;

  assign irq_flag_q       = 1'b0;
  assign irq_en_q         = 1'b0;
  assign unused_status_wr = status_wr;
`endif

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:4], writedata[2]};

  logic [7:0] rd_ext;
  logic [7:0] wr_ext;

  always_comb begin
    rd_ext                = '0;
    wr_ext                = '0;
    rd_ext[BUF_IDX_W-1:0] = rd_buf_q;
    wr_ext[BUF_IDX_W-1:0] = wr_buf_q;
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {29'b0, irq_en_q, 2'b0};
      2'd1: readdata = {8'b0, wr_ext, rd_ext, 6'b0, irq_flag_q, (state_q != ST_IDLE)};
      2'd2: readdata = 32'(frame_cnt_q);
      2'd3: readdata = 32'(swap_cnt_q);
      default: readdata = '0;
    endcase
  end

  assign rd_buf = rd_buf_q;
  assign wr_buf = wr_buf_q;
  assign irq    = irq_flag_q & irq_en_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb/tb_fb_swap_ctrl.sv - directed self-checking bench for fb_swap_ctrl
// Expectations follow FB_SWAP_IRQ_EN when defined for the whole compile.
module tb_fb_swap_ctrl;

`ifdef FB_SWAP_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        vsync;
  logic [0:0]  rd_buf;
  logic [0:0]  wr_buf;
  logic        irq;

  int vectors;
  int miscompares;

  logic [31:0] rdat;
  logic [7:0]  ef;
  logic [7:0]  es;
  logic        er;
  logic        ew;

  fb_swap_ctrl #(.BUF_IDX_W(1), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .vsync      (vsync),
    .rd_buf     (rd_buf),
    .wr_buf     (wr_buf),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    vsync       = 1'b0;
    ef = 8'd0; es = 8'd0; er = 1'b0; ew = 1'b1;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    rd(2'd1, rdat); chk("reset_status", rdat, 32'h0001_0000);
    rd(2'd2, rdat); chk("reset_frame", rdat, 32'h0);
    rd(2'd3, rdat); chk("reset_swap", rdat, 32'h0);
    rd(2'd0, rdat); chk("reset_ctrl", rdat, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // immediate swap: COMMIT visible in the cycle right after the write
    wr(2'd0, 32'h3);
    rd(2'd1, rdat); chk("imm_commit_pending", {31'b0, rdat[0]}, 32'h1);
    chk("imm_rd_before", {31'b0, rd_buf}, 32'h0);
    tick();
    er = 1'b1; ew = 1'b0; es = 8'd1;
    chk("imm_rd", {31'b0, rd_buf}, {31'b0, er});
    chk("imm_wr", {31'b0, wr_buf}, {31'b0, ew});
    rd(2'd3, rdat); chk("imm_swap", rdat, {24'b0, es});
    rd(2'd1, rdat); chk("imm_status", rdat, 32'h0000_0100 | {30'b0, IRQ, 1'b0});
    chk("imm_irq", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h2);
    rd(2'd1, rdat); chk("imm_clear", rdat, 32'h0000_0100);

    // deferred swap with IRQ enabled
    wr(2'd0, 32'h5);
    rd(2'd0, rdat); chk("ctrl_irq_en", rdat, {29'b0, IRQ, 2'b0});
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("defer_hold_rd", {31'b0, rd_buf}, 32'h1);
      rd(2'd1, rdat); chk("defer_pending", {31'b0, rdat[0]}, 32'h1);
    end
    vsync = 1'b1;
    tick();
    ef = 8'd1;
    chk("defer_rd_one_edge", {31'b0, rd_buf}, 32'h1);
    rd(2'd2, rdat); chk("defer_frame", rdat, {24'b0, ef});
    tick();
    er = 1'b0; ew = 1'b1; es = 8'd2;
    chk("defer_rd", {31'b0, rd_buf}, {31'b0, er});
    chk("defer_wr", {31'b0, wr_buf}, {31'b0, ew});
    rd(2'd3, rdat); chk("defer_swap", rdat, {24'b0, es});
    chk("defer_irq", {31'b0, irq}, {31'b0, IRQ});
    wr(2'd1, 32'h2);
    chk("defer_irq_clr", {31'b0, irq}, 32'h0);
    vsync = 1'b0;
    tick();

    // vsync already high when request lands: waits for the next rise
    vsync = 1'b1;
    tick();
    ef = 8'd2;
    tick();
    wr(2'd0, 32'h1);
    repeat (5) tick();
    rd(2'd1, rdat); chk("high_pending", {31'b0, rdat[0]}, 32'h1);
    rd(2'd3, rdat); chk("high_noswap", rdat, {24'b0, es});
    vsync = 1'b0;
    tick();
    wr(2'd0, 32'h1);
    tick();
    vsync = 1'b1;
    tick();
    ef = 8'd3;
    tick();
    er = 1'b1; ew = 1'b0; es = 8'd3;
    chk("high_rd", {31'b0, rd_buf}, {31'b0, er});
    chk("high_wr", {31'b0, wr_buf}, {31'b0, ew});
    vsync = 1'b0;
    repeat (3) tick();
    rd(2'd3, rdat); chk("high_swap_once", rdat, {24'b0, es});
    rd(2'd2, rdat); chk("high_frame", rdat, {24'b0, ef});
    rd(2'd1, rdat); chk("high_idle", {31'b0, rdat[0]}, 32'h0);
    chk("high_flag", {31'b0, rdat[1]}, {31'b0, IRQ});
    chk("high_irq_gated", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h2);

    // swap write coincident with vs_rise in IDLE does not use that edge
    vsync = 1'b1;
    wr(2'd0, 32'h1);
    ef = 8'd4;
    repeat (3) tick();
    rd(2'd1, rdat); chk("same_edge_pending", {31'b0, rdat[0]}, 32'h1);
    rd(2'd3, rdat); chk("same_edge_noswap", rdat, {24'b0, es});
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    ef = 8'd5;
    tick();
    er = 1'b0; ew = 1'b1; es = 8'd4;
    chk("same_edge_rd", {31'b0, rd_buf}, {31'b0, er});
    rd(2'd3, rdat); chk("same_edge_swap", rdat, {24'b0, es});
    vsync = 1'b0;
    tick();

    // clear in the COMMIT cycle loses to the set
    wr(2'd0, 32'h7);
    wr(2'd1, 32'h2);
    er = 1'b1; ew = 1'b0; es = 8'd5;
    chk("race_irq_set_wins", {31'b0, irq}, {31'b0, IRQ});
    chk("race_rd", {31'b0, rd_buf}, {31'b0, er});
    wr(2'd1, 32'h2);
    chk("race_irq_clr", {31'b0, irq}, 32'h0);

    // cancel coincident with vs_rise in PENDING: cancel wins
    wr(2'd0, 32'h1);
    tick();
    vsync = 1'b1;
    wr(2'd0, 32'h8);
    ef = 8'd6;
    rd(2'd1, rdat); chk("cancel_idle", {31'b0, rdat[0]}, 32'h0);
    repeat (2) tick();
    chk("cancel_rd", {31'b0, rd_buf}, {31'b0, er});
    rd(2'd3, rdat); chk("cancel_swap", rdat, {24'b0, es});
    rd(2'd2, rdat); chk("cancel_frame", rdat, {24'b0, ef});
    vsync = 1'b0;
    tick();

    // frame counter wraps modulo 2**CNT_W
    while (ef != 8'd0) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      ef = ef + 8'd1;
    end
    rd(2'd2, rdat); chk("frame_wrap", rdat, 32'h0);

    // reset while PENDING drops the request
    wr(2'd0, 32'h1);
    tick();
    rd(2'd1, rdat); chk("rst_pre_pending", {31'b0, rdat[0]}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rd", {31'b0, rd_buf}, 32'h0);
    chk("rst_wr", {31'b0, wr_buf}, 32'h1);
    rd(2'd1, rdat); chk("rst_status", rdat, 32'h0001_0000);
    rd(2'd3, rdat); chk("rst_swap", rdat, 32'h0);
    repeat (3) tick();
    chk("rst_no_late_swap", {31'b0, rd_buf}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
